// File: rtl/demux_pkg.sv
// Shared constants, select type and one-hot helper for the demux1to4 block.
package demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0] demux_sel_t;

  function automatic logic [NUM_OUT-1:0] sel_to_onehot(input demux_sel_t sel);
    return NUM_OUT'(1) << sel;
  endfunction

endpackage

// File: rtl/dec2to4.sv
// Combinational 2-to-4 one-hot decoder; drives both output enables and sel_oh.
module dec2to4
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] oh
);

  assign oh = sel_to_onehot(sel);

endmodule

// File: rtl/demux1to4.sv
// Registered 1-to-4 demultiplexer with one cycle of latency and a one-hot select status.
// Define DEMUX1TO4_HOLD_EN to make non-selected outputs keep their last value instead of clearing.
module demux1to4
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       sel_oh
);

  logic [NUM_OUT-1:0] dec_oh;
  logic [NUM_OUT-1:0] sel_oh_d, sel_oh_q;
  logic [WIDTH-1:0]   y_d [NUM_OUT];
  logic [WIDTH-1:0]   y_q [NUM_OUT];

  dec2to4 u_dec (
    .sel (s),
    .oh  (dec_oh)
  );

  always_comb begin
    sel_oh_d = dec_oh;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (dec_oh[k]) begin
        y_d[k] = a;
      end else begin
`ifdef DEMUX1TO4_HOLD_EN
        y_d[k] = y_q[k];
`else
        y_d[k] = '0;
`endif
      end
    end
  end

  // Reset wins over a/s on the same edge so no routing state survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_oh_q <= '0;
      for (int k = 0; k < NUM_OUT; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      sel_oh_q <= sel_oh_d;
      for (int k = 0; k < NUM_OUT; k++) begin
        y_q[k] <= y_d[k];
      end
    end
  end

  assign y0     = y_q[0];
  assign y1     = y_q[1];
  assign y2     = y_q[2];
  assign y3     = y_q[3];
  assign sel_oh = sel_oh_q;

endmodule

// File: tb/tb_demux1to4.sv
// Directed and scoreboarded bench for demux1to4 (WIDTH=8); honours DEMUX1TO4_HOLD_EN.
module tb_demux1to4;

  localparam int W = 8;
`ifdef DEMUX1TO4_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  // clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [1:0]   s;
  logic [W-1:0] y0, y1, y2, y3;
  logic [3:0]   sel_oh;

  always #5 clk = ~clk;

  demux1to4 #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .s      (s),
    .y0     (y0),
    .y1     (y1),
    .y2     (y2),
    .y3     (y3),
    .sel_oh (sel_oh)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // scoreboard: {sel_oh, y3, y2, y1, y0}
  logic [4*W+3:0] exp_q[$];

  function automatic logic [4*W+3:0] obs();
    return {sel_oh, y3, y2, y1, y0};
  endfunction

  task automatic check(input string tag, input logic [4*W+3:0] got, input logic [4*W+3:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: apply inputs on the falling edge, return 1 time unit after the rising edge
  task automatic drive(input logic r, input logic [W-1:0] av, input logic [1:0] sv);
    @(negedge clk);
    rst = r;
    a   = av;
    s   = sv;
    @(posedge clk);
    #1;
  endtask

  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  logic [W-1:0]   m_y [4];
  logic [3:0]     m_oh;
  logic [1:0]     prev_s;
  logic [1:0]     sv;
  logic [W-1:0]   av;
  logic [4*W+3:0] exp_v;
  int             nz;

  initial begin
    rst = 1'b1;
    a   = '0;
    s   = '0;

    // reset with inputs active: two reset edges
    drive(1'b1, 8'h01, 2'b10);
    check("reset_edge1", obs(), 36'h0_00000000);
    drive(1'b1, 8'h01, 2'b10);
    check("reset_edge2", obs(), 36'h0_00000000);

    // select sweep, a = 1
    drive(1'b0, 8'h01, 2'b00);
    check("sweep_s0", obs(), 36'h1_00000001);
    hold_cycles(3);
    check("sweep_s0_stable", obs(), 36'h1_00000001);

    // inputs change but no edge yet: outputs must not move
    @(negedge clk);
    s = 2'b01;
    #1;
    check("no_comb_path", obs(), 36'h1_00000001);
    @(posedge clk);
    #1;
    check("sweep_s1", obs(), HOLD ? 36'h2_00000101 : 36'h2_00000100);
    drive(1'b0, 8'h01, 2'b10);
    check("sweep_s2", obs(), HOLD ? 36'h4_00010101 : 36'h4_00010000);
    hold_cycles(2);
    check("sweep_s2_stable", obs(), HOLD ? 36'h4_00010101 : 36'h4_00010000);
    drive(1'b0, 8'h01, 2'b11);
    check("sweep_s3", obs(), HOLD ? 36'h8_01010101 : 36'h8_01000000);

    // data zero: sel_oh still shows routing
    drive(1'b0, 8'h00, 2'b01);
    check("data_zero", obs(), HOLD ? 36'h2_01010001 : 36'h2_00000000);
    drive(1'b0, 8'h01, 2'b01);
    check("data_zero_then_one", obs(), HOLD ? 36'h2_01010101 : 36'h2_00000100);

    // mid-operation reset
    drive(1'b0, 8'h01, 2'b11);
    check("mid_pre", obs(), HOLD ? 36'h8_01010101 : 36'h8_01000000);
    drive(1'b1, 8'h01, 2'b11);
    check("mid_reset", obs(), 36'h0_00000000);
    drive(1'b0, 8'h01, 2'b11);
    check("mid_release", obs(), 36'h8_01000000);

    // wide data, consecutive select change 00 -> 10
    drive(1'b0, 8'hA5, 2'b00);
    check("wide_s0", obs(), HOLD ? 36'h1_010000A5 : 36'h1_000000A5);
    drive(1'b0, 8'hA5, 2'b10);
    check("wide_s2", obs(), HOLD ? 36'h4_01A500A5 : 36'h4_00A50000);

    // back-to-back random selects from a clean reset
    drive(1'b1, 8'h00, 2'b00);
    check("rand_reset", obs(), 36'h0_00000000);
    for (int k = 0; k < 4; k++) m_y[k] = '0;
    prev_s = 2'b00;
    for (int i = 0; i < 24; i++) begin
      av = W'($urandom_range(0, 255));
      sv = prev_s + 2'($urandom_range(1, 3));
      prev_s = sv;
      m_oh = 4'b0001 << sv;
      for (int k = 0; k < 4; k++) begin
        if (k == int'(sv)) m_y[k] = av;
        else if (!HOLD) m_y[k] = '0;
      end
      exp_q.push_back({m_oh, m_y[3], m_y[2], m_y[1], m_y[0]});
      drive(1'b0, av, sv);
      exp_v = exp_q.pop_front();
      check($sformatf("rand_%0d", i), obs(), exp_v);
      if (!HOLD) begin
        nz = int'(y0 != 0) + int'(y1 != 0) + int'(y2 != 0) + int'(y3 != 0);
        check($sformatf("rand_single_nz_%0d", i), 36'(nz <= 1), 36'(1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
